board_updater_n: RTL

- Parametrised successor of the fixed-size Go board updater.
- Accepts a board, a move and the side to play, and places the stone.
- Removes captured opponent groups, then rejects the move for ko or suicide; classifies illegal moves with a result code.
- Adds four things: pass moves, an out-of-range check, an occupied-square check, and a capture count.
- Sits between the move-input controller and the game-state register bank.

---
 rtl/go_pkg.sv | 26 ++
 rtl/liberty_pruner_n.sv | 113 +++++++++++
 rtl/board_updater_n.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/go_pkg.sv
// Shared Go types: cell encoding, move result codes and the stone helper.
package go_pkg;

  // 2-bit cell encoding; RSVD is inert (no liberty, no group, never removed).
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    BLACK = 2'b01,
    WHITE = 2'b10,
    RSVD  = 2'b11
  } cell_t;

  // Outcome of a move request.
  typedef enum logic [2:0] {
    RES_OK        = 3'd0,
    RES_OCCUPIED  = 3'd1,
    RES_OFF_BOARD = 3'd2,
    RES_KO        = 3'd3,
    RES_SUICIDE   = 3'd4
  } result_t;

  // Stone colour of the side to play: 0 -> black, 1 -> white.
  function automatic cell_t stone_of(input logic turn);
    return cell_t'({turn, ~turn});
  endfunction

endpackage

// File: rtl/liberty_pruner_n.sv
// Removes every group of one colour that has no liberty.
// Ports:
//   clk_in, rst_in : clock, synchronous active-low reset
//   start_i        : strobe, latches colour_i and board_i (ignored while busy)
//   colour_i       : colour to prune
//   board_i        : position to prune
//   board_o        : pruned position, valid with done_o
//   removed_o      : number of stones removed
//   done_o         : one-cycle pulse when board_o/removed_o are updated
module liberty_pruner_n
  import go_pkg::*;
#(
  parameter int unsigned BOARD_N = 9,
  parameter int unsigned CAP_W   = $clog2(BOARD_N * BOARD_N + 1)
) (
  input  logic                                clk_in,
  input  logic                                rst_in,
  input  logic                                start_i,
  input  cell_t                               colour_i,
  input  logic [BOARD_N-1:0][BOARD_N-1:0][1:0] board_i,
  output logic [BOARD_N-1:0][BOARD_N-1:0][1:0] board_o,
  output logic [CAP_W-1:0]                    removed_o,
  output logic                                done_o
);

  typedef logic [BOARD_N-1:0][BOARD_N-1:0][1:0] board_t;
  typedef logic [BOARD_N-1:0][BOARD_N-1:0]      mask_t;
  typedef logic [BOARD_N+1:0][BOARD_N+1:0]      pad_t;

  typedef enum logic [1:0] {P_IDLE, P_SEED, P_SPREAD} pstate_t;

  pstate_t state_q;
  board_t  board_q;
  cell_t   col_q;
  mask_t   alive_q;

  mask_t      own_c, seed_c, grow_c;
  pad_t       emp_pad_c, alv_pad_c;
  board_t     cleared_c;
  logic [CAP_W-1:0] dead_cnt_c;

  // Neighbour maps are padded by one cell on every side so edges see "no neighbour".
  always_comb begin
    own_c      = '0;
    emp_pad_c  = '0;
    alv_pad_c  = '0;
    seed_c     = '0;
    grow_c     = '0;
    cleared_c  = board_q;
    dead_cnt_c = '0;
    for (int r = 0; r < int'(BOARD_N); r++) begin
      for (int c = 0; c < int'(BOARD_N); c++) begin
        own_c[r][c]             = (board_q[r][c] == col_q);
        emp_pad_c[r+1][c+1]     = (board_q[r][c] == 2'b00);
        alv_pad_c[r+1][c+1]     = alive_q[r][c];
      end
    end
    for (int r = 0; r < int'(BOARD_N); r++) begin
      for (int c = 0; c < int'(BOARD_N); c++) begin
        seed_c[r][c] = own_c[r][c] &
                       (emp_pad_c[r][c+1] | emp_pad_c[r+2][c+1] |
                        emp_pad_c[r+1][c] | emp_pad_c[r+1][c+2]);
        grow_c[r][c] = alive_q[r][c] | (own_c[r][c] &
                       (alv_pad_c[r][c+1] | alv_pad_c[r+2][c+1] |
                        alv_pad_c[r+1][c] | alv_pad_c[r+1][c+2]));
        if (own_c[r][c] && !alive_q[r][c]) begin
          cleared_c[r][c] = 2'b00;
          dead_cnt_c      = dead_cnt_c + CAP_W'(1);
        end
      end
    end
  end

  // Latch, seed liberties, then flood alive marks until they stop changing.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q   <= P_IDLE;
      board_q   <= '0;
      col_q     <= EMPTY;
      alive_q   <= '0;
      board_o   <= '0;
      removed_o <= '0;
      done_o    <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state_q)
        P_IDLE: begin
          if (start_i) begin
            board_q <= board_i;
            col_q   <= colour_i;
            state_q <= P_SEED;
          end
        end
        P_SEED: begin
          alive_q <= seed_c;
          state_q <= P_SPREAD;
        end
        P_SPREAD: begin
          if (grow_c == alive_q) begin
            board_o   <= cleared_c;
            removed_o <= dead_cnt_c;
            done_o    <= 1'b1;
            state_q   <= P_IDLE;
          end else begin
            alive_q <= grow_c;
          end
        end
        default: state_q <= P_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/board_updater_n.sv
// Applies one Go move: placement, opponent capture, ko and suicide rejection.
// Ports:
//   clk_in, rst_in       : clock, synchronous active-low reset
//   start / ready        : request strobe, accepted only while ready (IDLE)
//   board_in, ko_board   : current position and ko-forbidden position
//   turn, pass_in        : side to play (0 black, 1 white), pass request
//   move_row, move_col   : move coordinates
//   next_board, result,
//   captures, done       : registered outcome, updated with the done pulse
module board_updater_n
  import go_pkg::*;
#(
  parameter int unsigned BOARD_N = 9,
  parameter int unsigned COORD_W = $clog2(BOARD_N),
  parameter int unsigned CAP_W   = $clog2(BOARD_N * BOARD_N + 1)
) (
  input  logic                                clk_in,
  input  logic                                rst_in,
  input  logic                                start,
  output logic                                ready,
  input  logic [BOARD_N-1:0][BOARD_N-1:0][1:0] board_in,
  input  logic [BOARD_N-1:0][BOARD_N-1:0][1:0] ko_board,
  input  logic                                turn,
  input  logic                                pass_in,
  input  logic [COORD_W-1:0]                  move_row,
  input  logic [COORD_W-1:0]                  move_col,
  output logic [BOARD_N-1:0][BOARD_N-1:0][1:0] next_board,
  output logic                                done,
  output logic [2:0]                          result,
  output logic [CAP_W-1:0]                    captures
);

  typedef logic [BOARD_N-1:0][BOARD_N-1:0][1:0] board_t;

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_PLACE, S_PRUNE_OPP, S_KO_CHECK, S_PRUNE_SELF, S_DONE
  } state_t;

  state_t           state_q;
  board_t           board_q, ko_q, work_q;
  logic             turn_q, pass_q;
  logic [COORD_W-1:0] row_q, col_q;
  result_t          res_q;
  logic [CAP_W-1:0] cap_q;
  logic             prn_start_q;
  cell_t            prn_col_q;

  board_t           prn_board;
  logic [CAP_W-1:0] prn_removed;
  logic             prn_done;

  logic             off_board_c;
  logic             occupied_c;
  board_t           placed_c;

  // Move legality pre-checks and the board with the new stone written in.
  always_comb begin
    off_board_c = (32'(row_q) >= BOARD_N) || (32'(col_q) >= BOARD_N);
    occupied_c  = 1'b0;
    placed_c    = board_q;
    if (!off_board_c) begin
      occupied_c              = (board_q[row_q][col_q] != 2'b00);
      placed_c[row_q][col_q]  = stone_of(turn_q);
    end
  end

  liberty_pruner_n #(
    .BOARD_N (BOARD_N),
    .CAP_W   (CAP_W)
  ) u_pruner (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .start_i   (prn_start_q),
    .colour_i  (prn_col_q),
    .board_i   (work_q),
    .board_o   (prn_board),
    .removed_o (prn_removed),
    .done_o    (prn_done)
  );

  // Move sequencer; outputs change only in DONE so they hold between results.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q     <= S_IDLE;
      board_q     <= '0;
      ko_q        <= '0;
      work_q      <= '0;
      turn_q      <= 1'b0;
      pass_q      <= 1'b0;
      row_q       <= '0;
      col_q       <= '0;
      res_q       <= RES_OK;
      cap_q       <= '0;
      prn_start_q <= 1'b0;
      prn_col_q   <= EMPTY;
      ready       <= 1'b1;
      done        <= 1'b0;
      result      <= 3'(RES_OK);
      captures    <= '0;
      next_board  <= '0;
    end else begin
      done        <= 1'b0;
      prn_start_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            board_q <= board_in;
            ko_q    <= ko_board;
            turn_q  <= turn;
            pass_q  <= pass_in;
            row_q   <= move_row;
            col_q   <= move_col;
            res_q   <= RES_OK;
            cap_q   <= '0;
            ready   <= 1'b0;
            state_q <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (pass_q) begin
            work_q  <= board_q;
            res_q   <= RES_OK;
            state_q <= S_DONE;
          end else if (off_board_c) begin
            res_q   <= RES_OFF_BOARD;
            state_q <= S_DONE;
          end else if (occupied_c) begin
            res_q   <= RES_OCCUPIED;
            state_q <= S_DONE;
          end else begin
            state_q <= S_PLACE;
          end
        end
        S_PLACE: begin
          work_q      <= placed_c;
          prn_col_q   <= stone_of(~turn_q);
          prn_start_q <= 1'b1;
          state_q     <= S_PRUNE_OPP;
        end
        S_PRUNE_OPP: begin
          if (prn_done) begin
            work_q  <= prn_board;
            cap_q   <= prn_removed;
            state_q <= S_KO_CHECK;
          end
        end
        S_KO_CHECK: begin
          if (work_q == ko_q) begin
            res_q   <= RES_KO;
            state_q <= S_DONE;
          end else begin
            prn_col_q   <= stone_of(turn_q);
            prn_start_q <= 1'b1;
            state_q     <= S_PRUNE_SELF;
          end
        end
        S_PRUNE_SELF: begin
          // Any own stone removed means the move left its own group dead.
          if (prn_done) begin
            res_q   <= (prn_board != work_q) ? RES_SUICIDE : RES_OK;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          done   <= 1'b1;
          ready  <= 1'b1;
          result <= 3'(res_q);
          if (res_q == RES_OK) begin
            next_board <= work_q;
            captures   <= cap_q;
          end else begin
            next_board <= board_q;
            captures   <= '0;
          end
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
